// File: rtl/jtag_uart_host_pkg.sv
// rtl/jtag_uart_host_pkg.sv - register map, field bounds and FSM encoding for the JTAG-UART Wishbone host
package jtag_uart_host_pkg;

    localparam logic       DATA_ADDR   = 1'b0;
    localparam logic       CTRL_ADDR   = 1'b1;
    localparam int         RVALID_BIT  = 15;
    localparam int         FIELD_HI    = 31;
    localparam int         FIELD_LO    = 16;
    localparam logic [2:0] CTI_CLASSIC = 3'b000;

    typedef enum logic [1:0] {
        IDLE,
        WR_DATA,
        RD_CTRL,
        RD_DATA
    } state_t;

endpackage

// File: rtl/jtag_uart_byte_fifo.sv
// rtl/jtag_uart_byte_fifo.sv - synchronous show-ahead byte FIFO
module jtag_uart_byte_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [DW-1:0]            din,
    input  logic                     pop,
    output logic [DW-1:0]            dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign w_pop  = pop & (r_count != '0);
    assign w_push = push & ((r_count != (AW+1)'(DEPTH)) | w_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (w_pop && !w_push) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= din;
    end

    assign dout  = r_mem[r_rptr];
    assign empty = (r_count == '0);
    assign full  = (r_count == (AW+1)'(DEPTH));
    assign count = r_count;

endmodule

// File: rtl/jtag_uart_wb_host.sv
// rtl/jtag_uart_wb_host.sv - Wishbone classic master bridging a byte stream to a JTAG-UART slave
module jtag_uart_wb_host
    import jtag_uart_host_pkg::*;
#(
    parameter int POLL_INTERVAL = 1024,
    parameter int RX_FIFO_DEPTH = 4,
    parameter int ACK_TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] m_dat_o,
    output logic [3:0]  m_sel_o,
    output logic        m_addr_o,
    output logic [2:0]  m_cti_o,
    output logic        m_stb_o,
    output logic        m_cyc_o,
    output logic        m_we_o,
    input  logic [31:0] m_dat_i,
    input  logic        m_ack_i,
    input  logic        irq_i,
    input  logic [7:0]  tx_din,
    input  logic        tx_wr,
    output logic        tx_ready,
    output logic [7:0]  rx_dout,
    output logic        rx_valid,
    input  logic        rx_rd,
    output logic        bus_err
);
    localparam int PW = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam int CW = $clog2(RX_FIFO_DEPTH) + 1;

    state_t        r_state;
    state_t        w_next;
    logic [PW-1:0] r_poll_cnt;
    logic [TW-1:0] r_to_cnt;
    logic          r_tx_pend;
    logic [7:0]    r_tx_byte;
    logic [15:0]   r_wspace;
    logic          r_rx_more;
    logic          r_bus_err;

    logic          w_tick;
    logic          w_poll_req;
    logic          w_busy;
    logic          w_ack;
    logic          w_timeout;
    logic          w_room;
    logic          w_rx_pop;
    logic          w_rx_push;
    logic          w_fifo_empty;
    logic          w_fifo_full;
    logic [CW-1:0] w_fifo_count;
    logic          w_unused_dat;

    assign w_tick     = (r_poll_cnt == PW'(POLL_INTERVAL - 1));
    assign w_poll_req = w_tick | irq_i | r_rx_more;
    assign w_busy     = (r_state != IDLE);
    assign w_ack      = w_busy & m_ack_i;
    assign w_timeout  = (ACK_TIMEOUT != 0) && w_busy && !m_ack_i
                        && (r_to_cnt == TW'(ACK_TIMEOUT - 1));
    assign w_room     = (w_fifo_count < CW'(RX_FIFO_DEPTH));
    assign w_rx_pop   = rx_rd & ~w_fifo_empty;
    assign w_rx_push  = w_ack && (r_state == RD_DATA) && m_dat_i[RVALID_BIT]
                        && (!w_fifo_full || w_rx_pop);
    assign w_unused_dat = ^m_dat_i[RVALID_BIT-1:8];

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (r_tx_pend && r_wspace != 16'd0)  w_next = WR_DATA;
                else if (r_tx_pend && w_poll_req)    w_next = RD_CTRL;
                else if (w_poll_req && w_room)       w_next = RD_DATA;
            end
            default: begin
                if (m_ack_i || w_timeout) w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_poll_cnt <= '0;
            r_to_cnt   <= '0;
            r_tx_pend  <= 1'b0;
            r_tx_byte  <= 8'd0;
            r_wspace   <= 16'd0;
            r_rx_more  <= 1'b0;
            r_bus_err  <= 1'b0;
        end else begin
            r_poll_cnt <= w_tick ? '0 : r_poll_cnt + 1'b1;
            r_to_cnt   <= (w_busy && !m_ack_i) ? r_to_cnt + 1'b1 : '0;
            if (tx_wr && !r_tx_pend) begin
                r_tx_pend <= 1'b1;
                r_tx_byte <= tx_din;
            end
            if (w_timeout) r_bus_err <= 1'b1;
            if (w_ack) begin
                case (r_state)
                    WR_DATA: begin
                        r_tx_pend <= 1'b0;
                        if (r_wspace != 16'd0) r_wspace <= r_wspace - 16'd1;
                    end
                    RD_CTRL: r_wspace <= m_dat_i[FIELD_HI:FIELD_LO];
                    RD_DATA: r_rx_more <= m_dat_i[RVALID_BIT]
                                          & (m_dat_i[FIELD_HI:FIELD_LO] != 16'd0);
                    default: ;
                endcase
            end
        end
    end

    jtag_uart_byte_fifo #(
        .DEPTH (RX_FIFO_DEPTH),
        .DW    (8)
    ) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_rx_push),
        .din   (m_dat_i[7:0]),
        .pop   (w_rx_pop),
        .dout  (rx_dout),
        .empty (w_fifo_empty),
        .full  (w_fifo_full),
        .count (w_fifo_count)
    );

    assign m_cyc_o  = w_busy;
    assign m_stb_o  = w_busy;
    assign m_we_o   = (r_state == WR_DATA);
    assign m_addr_o = (r_state == RD_CTRL) ? CTRL_ADDR : DATA_ADDR;
    assign m_dat_o  = (r_state == WR_DATA) ? {24'd0, r_tx_byte} : 32'd0;
    assign m_sel_o  = 4'b1111;
    assign m_cti_o  = CTI_CLASSIC;
    assign tx_ready = ~r_tx_pend;
    assign rx_valid = ~w_fifo_empty;
    assign bus_err  = r_bus_err;

endmodule

// File: tb/tb_jtag_uart_wb_host.sv
// tb/tb_jtag_uart_wb_host.sv - self-checking bench for jtag_uart_wb_host
module tb_jtag_uart_wb_host;
    localparam int POLL = 64;

    logic        clk;
    logic        reset;
    logic [31:0] m_dat_o;
    logic [3:0]  m_sel_o;
    logic        m_addr_o;
    logic [2:0]  m_cti_o;
    logic        m_stb_o;
    logic        m_cyc_o;
    logic        m_we_o;
    logic [31:0] m_dat_i;
    logic        m_ack_i;
    logic        irq_i;
    logic [7:0]  tx_din;
    logic        tx_wr;
    logic        tx_ready;
    logic [7:0]  rx_dout;
    logic        rx_valid;
    logic        rx_rd;
    logic        bus_err;

    jtag_uart_wb_host #(
        .POLL_INTERVAL (POLL),
        .RX_FIFO_DEPTH (4),
        .ACK_TIMEOUT   (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .m_dat_o  (m_dat_o),
        .m_sel_o  (m_sel_o),
        .m_addr_o (m_addr_o),
        .m_cti_o  (m_cti_o),
        .m_stb_o  (m_stb_o),
        .m_cyc_o  (m_cyc_o),
        .m_we_o   (m_we_o),
        .m_dat_i  (m_dat_i),
        .m_ack_i  (m_ack_i),
        .irq_i    (irq_i),
        .tx_din   (tx_din),
        .tx_wr    (tx_wr),
        .tx_ready (tx_ready),
        .rx_dout  (rx_dout),
        .rx_valid (rx_valid),
        .rx_rd    (rx_rd),
        .bus_err  (bus_err)
    );

    typedef struct {
        logic        addr;
        logic        we;
        logic [31:0] dat;
        int          stamp;
    } xfer_t;

    typedef struct {
        logic [31:0] word;
        logic        exp_valid;
        logic [7:0]  exp_byte;
        int          exp_reads;
    } rx_vec_t;

    xfer_t       xlog[$];
    logic [31:0] data_q[$];
    logic [31:0] ctrl_resp;
    bit          slave_en;
    int          cycle_n;
    int          n_pass;
    int          n_total;
    rx_vec_t     vecs[6];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cycle_n = 0;
        forever begin
            @(posedge clk);
            cycle_n++;
        end
    end

    // Slave model: ack one cycle after the strobe is seen, log every completed transfer.
    initial begin
        m_ack_i = 1'b0;
        m_dat_i = 32'd0;
        forever begin
            @(negedge clk);
            if (m_cyc_o && m_stb_o && !m_ack_i && slave_en) begin
                xfer_t x;
                m_ack_i = 1'b1;
                if (m_we_o) m_dat_i = 32'd0;
                else if (m_addr_o) m_dat_i = ctrl_resp;
                else if (data_q.size() > 0) m_dat_i = data_q.pop_front();
                else m_dat_i = 32'd0;
                x.addr  = m_addr_o;
                x.we    = m_we_o;
                x.dat   = m_we_o ? m_dat_o : m_dat_i;
                x.stamp = cycle_n;
                xlog.push_back(x);
            end else begin
                m_ack_i = 1'b0;
                m_dat_i = 32'd0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks passed %0d of %0d", n_pass, n_total);
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic chk_xfer(input string name, input int k, input logic a, input logic w, input logic [31:0] d);
        if (k < xlog.size()) check(name, {xlog[k].addr, xlog[k].we, xlog[k].dat}, {a, w, d});
        else check({name, "_present"}, 64'(xlog.size()), 64'(k + 1));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        irq_i = 1'b0;
        tx_wr = 1'b0;
        rx_rd = 1'b0;
        slave_en = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        xlog.delete();
        data_q.delete();
    endtask

    task automatic send_tx(input logic [7:0] b);
        tx_din = b;
        tx_wr  = 1'b1;
        @(negedge clk);
        tx_wr  = 1'b0;
    endtask

    task automatic pulse_irq();
        irq_i = 1'b1;
        @(negedge clk);
        irq_i = 1'b0;
    endtask

    task automatic wait_bus(input bit want_we, input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (m_cyc_o && (!want_we || m_we_o)) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            n_total++;
            $display("FAIL %s: no bus cycle within 200 cycles", name);
        end
    endtask

    task automatic wait_log(input int n, input string name);
        for (int i = 0; i < 300 && xlog.size() < n; i++) @(negedge clk);
        check(name, 64'(xlog.size() >= n), 64'd1);
    endtask

    initial begin
        bit ok;
        int hi;
        n_pass = 0;
        n_total = 0;
        reset = 1'b1;
        irq_i = 1'b0;
        tx_din = 8'd0;
        tx_wr = 1'b0;
        rx_rd = 1'b0;
        ctrl_resp = 32'd0;
        slave_en = 1'b1;

        vecs[0] = '{32'h0000_0000, 1'b0, 8'h00, 1};
        vecs[1] = '{32'h0000_8041, 1'b1, 8'h41, 1};
        vecs[2] = '{32'h0003_8042, 1'b1, 8'h42, 2};
        vecs[3] = '{32'h0005_0043, 1'b0, 8'h00, 1};
        vecs[4] = '{32'hFFFF_00FF, 1'b0, 8'h00, 1};
        vecs[5] = '{32'h0001_80FF, 1'b1, 8'hFF, 2};

        do_reset();
        check("rst_cyc", m_cyc_o, 0);
        check("rst_stb", m_stb_o, 0);
        check("rst_we", m_we_o, 0);
        check("rst_addr", m_addr_o, 0);
        check("rst_dat", m_dat_o, 0);
        check("rst_sel", m_sel_o, 4'hF);
        check("rst_cti", m_cti_o, 3'b000);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_bus_err", bus_err, 0);

        foreach (vecs[i]) begin
            do_reset();
            data_q.push_back(vecs[i].word);
            pulse_irq();
            repeat (12) @(negedge clk);
            check($sformatf("vec%0d_reads", i), 64'(xlog.size()), 64'(vecs[i].exp_reads));
            chk_xfer($sformatf("vec%0d_rd", i), 0, 1'b0, 1'b0, vecs[i].word);
            check($sformatf("vec%0d_valid", i), rx_valid, vecs[i].exp_valid);
            if (vecs[i].exp_valid) check($sformatf("vec%0d_byte", i), rx_dout, vecs[i].exp_byte);
        end

        do_reset();
        ctrl_resp = 32'h0040_0000;
        send_tx(8'h41);
        check("tx41_busy", tx_ready, 0);
        wait_bus(1'b1, "tx41_wr", ok);
        if (ok) begin
            check("tx41_dat", m_dat_o, 32'h0000_0041);
            check("tx41_addr", m_addr_o, 0);
            check("tx41_ready_in_cycle", tx_ready, 0);
            @(negedge clk);
            check("tx41_cyc_drop", m_cyc_o, 0);
            check("tx41_ready_after", tx_ready, 1);
        end
        chk_xfer("tx41_ctrl_first", 0, 1'b1, 1'b0, 32'h0040_0000);
        chk_xfer("tx41_write", 1, 1'b0, 1'b1, 32'h0000_0041);

        do_reset();
        data_q.push_back(32'h0002_8055);
        data_q.push_back(32'h0001_8056);
        data_q.push_back(32'h0000_8057);
        pulse_irq();
        repeat (15) @(negedge clk);
        check("b2b_reads", 64'(xlog.size()), 64'd3);
        if (xlog.size() == 3) begin
            check("b2b_gap1", 64'(xlog[1].stamp - xlog[0].stamp), 64'd2);
            check("b2b_gap2", 64'(xlog[2].stamp - xlog[1].stamp), 64'd2);
        end
        for (int k = 0; k < 3; k++) begin
            check($sformatf("b2b_valid%0d", k), rx_valid, 1);
            check($sformatf("b2b_byte%0d", k), rx_dout, 8'h55 + 8'(k));
            rx_rd = 1'b1;
            @(negedge clk);
            rx_rd = 1'b0;
        end
        check("b2b_drained", rx_valid, 0);

        do_reset();
        for (int k = 0; k < 6; k++) data_q.push_back(32'h0000_80A0 + 32'(k));
        irq_i = 1'b1;
        repeat (20) @(negedge clk);
        check("full_reads", 64'(xlog.size()), 64'd4);
        check("full_head", rx_dout, 8'hA0);
        rx_rd = 1'b1;
        @(negedge clk);
        rx_rd = 1'b0;
        repeat (10) @(negedge clk);
        check("full_one_more", 64'(xlog.size()), 64'd5);
        check("full_head_pop", rx_dout, 8'hA1);
        irq_i = 1'b0;

        do_reset();
        slave_en = 1'b0;
        send_tx(8'h5A);
        pulse_irq();
        wait_bus(1'b0, "to_issue", ok);
        if (ok) begin
            check("to_addr_ctrl", m_addr_o, 1);
            hi = 1;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (!m_cyc_o) break;
                hi++;
            end
            check("to_cyc_len", 64'(hi), 64'd8);
        end
        check("to_bus_err", bus_err, 1);
        check("to_tx_pending", tx_ready, 0);
        check("to_no_push", rx_valid, 0);
        slave_en = 1'b1;
        ctrl_resp = 32'h0040_0000;
        pulse_irq();
        repeat (10) @(negedge clk);
        chk_xfer("to_retry_ctrl", 0, 1'b1, 1'b0, 32'h0040_0000);
        chk_xfer("to_retry_wr", 1, 1'b0, 1'b1, 32'h0000_005A);
        check("to_tx_done", tx_ready, 1);
        check("to_err_sticky", bus_err, 1);

        do_reset();
        ctrl_resp = 32'h0001_0000;
        send_tx(8'h31);
        wait_bus(1'b1, "ws_wr1", ok);
        repeat (2) @(negedge clk);
        check("ws_ready", tx_ready, 1);
        ctrl_resp = 32'h0000_0000;
        send_tx(8'h32);
        wait_log(4, "ws_zero_polls");
        ctrl_resp = 32'h0001_0000;
        wait_log(6, "ws_second_wr");
        chk_xfer("ws_x0", 0, 1'b1, 1'b0, 32'h0001_0000);
        chk_xfer("ws_x1", 1, 1'b0, 1'b1, 32'h0000_0031);
        chk_xfer("ws_x2", 2, 1'b1, 1'b0, 32'h0000_0000);
        chk_xfer("ws_x3", 3, 1'b1, 1'b0, 32'h0000_0000);
        chk_xfer("ws_x4", 4, 1'b1, 1'b0, 32'h0001_0000);
        chk_xfer("ws_x5", 5, 1'b0, 1'b1, 32'h0000_0032);
        if (xlog.size() >= 5) begin
            check("ws_poll_gap1", 64'(xlog[3].stamp - xlog[2].stamp), 64'(POLL));
            check("ws_poll_gap2", 64'(xlog[4].stamp - xlog[3].stamp), 64'(POLL));
        end

        do_reset();
        data_q.push_back(32'h0000_8077);
        pulse_irq();
        repeat (4) @(negedge clk);
        check("mr_pre_valid", rx_valid, 1);
        slave_en = 1'b0;
        pulse_irq();
        send_tx(8'h11);
        check("mr_pre_cyc", m_cyc_o, 1);
        check("mr_pre_tx", tx_ready, 0);
        reset = 1'b1;
        @(negedge clk);
        check("mr_cyc", m_cyc_o, 0);
        check("mr_stb", m_stb_o, 0);
        check("mr_fifo_empty", rx_valid, 0);
        check("mr_tx_ready", tx_ready, 1);
        check("mr_bus_err", bus_err, 0);
        reset = 1'b0;
        slave_en = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
